spectrum_frame_packer: RTL and testbench
========================================

Name: spectrum_frame_packer

Overview:
- Downstream stage of the signal-processing user logic.
- Consumes the 64-bit accumulated power-spectrum word stream produced after the upload switcher.
- Wraps each upload in a frame: a header word, a buffered payload, and a trailer word carrying a checksum.
- Presents the result on the four 16-bit output lanes (y0, y0z, y1, y1z) with a data-valid strobe and downstream backpressure.

Parameters:
- FIFO_DEPTH, 512, payload buffer depth in 64-bit words (power of two).
- SYNC_HEAD, 16'hA55A, header sync marker.
- SYNC_TAIL, 16'h5AA5, trailer sync marker.

Ports:
- clk_i  in  1  sole clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- frame_start_i  in  1  one-cycle pulse that opens a frame (upload start).
- n_points_i  in  16  64-bit words per range bin; sampled on frame_start_i.
- n_bins_i  in  16  range bins per frame; sampled on frame_start_i.
- pulse_count_i  in  16  accumulated pulse count; sampled on frame_start_i.
- data_i  in  64  spectrum word.
- valid_i  in  1  data_i qualifier; no backpressure upstream.
- ready_i  in  1  downstream accepts output word this cycle.
- y0_o  out  16  out word [63:48].
- y0z_o  out  16  out word [47:32].
- y1_o  out  16  out word [31:16].
- y1z_o  out  16  out word [15:0].
- data_valid_o  out  1  output word valid.
- busy_o  out  1  frame in progress.
- overflow_o  out  1  sticky: FIFO full on write, or word received outside a frame or beyond the expected count.
- frame_cnt_o  out  16  completed frames.

Behaviour:
- Reset (rst_n_i low, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, frame counter 0, overflow cleared.
- Output register handshake:
  - Word transfers when data_valid_o && ready_i.
  - While data_valid_o=1 && ready_i=0, y*_o hold stable.
- Frame latch: on frame_start_i in IDLE, latch pulse_count_i and latch expected = n_points_i*n_bins_i (32-bit). Clear payload word counter and checksum.
- frame_start_i outside IDLE is ignored and does not set overflow.
- FIFO write:
  - valid_i while busy_o, FIFO not full and received count < expected: write and increment received count.
  - Otherwise the word is dropped and overflow_o is set.
  - Payload words may arrive in the same cycle as frame_start_i; such a word is captured.
- FSM states:
  - IDLE -> HEADER on frame_start_i.
  - HEADER: load the output register with {SYNC_HEAD, frame_cnt_o, n_bins latched, pulse_count latched}.
    - If expected=0, go to TRAILER after the header transfers.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: pop the FIFO into the output register whenever the register is empty or transferring, and the FIFO is not empty.
    - Checksum ^= the four 16-bit lanes XORed together.
    - Sent counter += 1.
    - When sent == expected and the last word transfers, go to TRAILER.
  - TRAILER: output {SYNC_TAIL, sent[15:0], sent[31:16], checksum}. On transfer: frame_cnt_o += 1 (wraps at 16'hFFFF->0), then go to IDLE.
- busy_o: 1 from the cycle after frame_start_i until the trailer transfers.
- Latency: a payload word written at cycle t may appear on y*_o no earlier than t+2 with ready_i held 1.
- Throughput: with ready_i held 1, one word per cycle; no bubbles while the FIFO is non-empty.
- Simultaneous FIFO read and write when full: the write is accepted.

Test Plan:
- Reset mid-PAYLOAD (rst_n_i low 1 cycle) -> all outputs 0, busy_o=0, overflow_o=0, frame_cnt_o=0 immediately, with no clock needed.
- frame_start_i with n_points=4, n_bins=2, pulse_count=16'd100, then 8 words 64'h0001_0002_0003_0004+i with ready_i=1 -> the following 10 consecutive valid words:
  - header A55A_0000_0002_0064,
  - the 8 payload words in order,
  - trailer {5AA5, 0008, 0000, XOR of all lanes};
  - frame_cnt_o=1, overflow_o=0.
- Same frame with ready_i toggled 1,0,0,1,… -> identical word sequence; outputs stable during stall cycles.
- Expected=4 but 6 words driven -> 4 payload words plus the trailer are emitted, overflow_o=1 and stays 1 until reset.
- ready_i=0 throughout while FIFO_DEPTH+2 words arrive -> overflow_o=1. Release ready_i -> FIFO_DEPTH words are emitted, then the frame stalls in PAYLOAD with busy_o=1.
- n_points=0 -> header then trailer {5AA5,0000,0000,0000}. A second frame_start_i during busy is ignored.

Source files
------------

// File: rtl/spectrum_frame_packer.sv
// Spectrum frame packer: wraps each upload of 64-bit power-spectrum words in a
// header / payload / trailer frame and drives it onto four 16-bit lanes with a
// valid/ready handshake. Payload is buffered in a FIFO so the upstream (which
// cannot be stalled) keeps streaming while downstream applies backpressure.
module spectrum_frame_packer #(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [15:0] SYNC_HEAD  = 16'hA55A,
  parameter logic [15:0] SYNC_TAIL  = 16'h5AA5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        frame_start_i,
  input  logic [15:0] n_points_i,
  input  logic [15:0] n_bins_i,
  input  logic [15:0] pulse_count_i,
  input  logic [63:0] data_i,
  input  logic        valid_i,
  input  logic        ready_i,
  output logic [15:0] y0_o,
  output logic [15:0] y0z_o,
  output logic [15:0] y1_o,
  output logic [15:0] y1z_o,
  output logic        data_valid_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic [15:0] frame_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
  state_t state;

  logic [63:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [31:0] exp_q, rcv_q, sent_q;
  logic [15:0] csum_q, fcnt_q;
  logic [63:0] out_q;
  logic        out_vld, busy_q, ovf_q;

  logic        start, fifo_empty, fifo_full, xfer, out_free, more, pop, wr_ok;
  logic [31:0] exp_now, rcv_now;
  logic [63:0] rd_word, trailer;
  logic [15:0] lane_x;

  // A start is only honoured in IDLE; a word arriving in the same cycle is
  // judged against the count being latched right now, not the stale one.
  assign start      = frame_start_i && (state == IDLE);
  assign exp_now    = start ? ({16'b0, n_points_i} * {16'b0, n_bins_i}) : exp_q;
  assign rcv_now    = start ? 32'd0 : rcv_q;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign xfer       = out_vld && ready_i;
  assign out_free   = !out_vld || ready_i;
  assign more       = (sent_q != exp_q);
  // The header slot hands straight over to the first payload word so the
  // frame streams without a bubble.
  assign pop        = !fifo_empty && more &&
                      (((state == PAYLOAD) && out_free) || ((state == HEADER) && xfer));
  // A read in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign wr_ok      = valid_i && (busy_q || start) && (!fifo_full || pop) && (rcv_now < exp_now);
  assign rd_word    = mem[rptr[AW-1:0]];
  assign lane_x     = rd_word[63:48] ^ rd_word[47:32] ^ rd_word[31:16] ^ rd_word[15:0];
  assign trailer    = {SYNC_TAIL, sent_q[15:0], sent_q[31:16], csum_q};

  // Payload storage; no reset needed, pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= data_i;
  end

  // Frame FSM, FIFO pointers, counters and the output register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      exp_q   <= '0;
      rcv_q   <= '0;
      sent_q  <= '0;
      csum_q  <= '0;
      fcnt_q  <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (start || wr_ok) rcv_q <= rcv_now + {31'b0, wr_ok};
      if (valid_i && !wr_ok) ovf_q <= 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        out_q   <= rd_word;
        out_vld <= 1'b1;
        csum_q  <= csum_q ^ lane_x;
        sent_q  <= sent_q + 32'd1;
      end
      unique case (state)
        IDLE: if (frame_start_i) begin
          exp_q   <= exp_now;
          sent_q  <= '0;
          csum_q  <= '0;
          out_q   <= {SYNC_HEAD, fcnt_q, n_bins_i, pulse_count_i};
          out_vld <= 1'b1;
          busy_q  <= 1'b1;
          state   <= HEADER;
        end
        HEADER: if (xfer) begin
          if (exp_q == 32'd0) begin
            out_q <= trailer;
            state <= TRAILER;
          end else begin
            if (!pop) out_vld <= 1'b0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: if (!more && out_free) begin
          out_q   <= trailer;
          out_vld <= 1'b1;
          state   <= TRAILER;
        end else if (xfer && !pop) begin
          out_vld <= 1'b0;
        end
        TRAILER: if (xfer) begin
          out_vld <= 1'b0;
          busy_q  <= 1'b0;
          fcnt_q  <= fcnt_q + 16'd1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {y0_o, y0z_o, y1_o, y1z_o} = out_q;
  assign data_valid_o = out_vld;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;
  assign frame_cnt_o  = fcnt_q;
endmodule

// File: tb/tb_spectrum_frame_packer.sv
// Bench for spectrum_frame_packer: a frame-level model builds the expected
// word stream (header, accepted payload, trailer); one negedge process checks
// every transferred word and output stability during stalls.
module tb_spectrum_frame_packer;
  localparam int DEPTH = 16;

  logic        clk, rst_n, frame_start_i, valid_i, ready_i;
  logic [15:0] n_points_i, n_bins_i, pulse_count_i;
  logic [63:0] data_i;
  logic [15:0] y0, y0z, y1, y1z, frame_cnt_o;
  logic        data_valid_o, busy_o, overflow_o;

  spectrum_frame_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(frame_start_i),
    .n_points_i(n_points_i), .n_bins_i(n_bins_i), .pulse_count_i(pulse_count_i),
    .data_i(data_i), .valid_i(valid_i), .ready_i(ready_i),
    .y0_o(y0), .y0z_o(y0z), .y1_o(y1), .y1z_o(y1z),
    .data_valid_o(data_valid_o), .busy_o(busy_o), .overflow_o(overflow_o),
    .frame_cnt_o(frame_cnt_o));

  typedef struct packed {logic [63:0] w; logic pay;} item_t;

  int checks = 0, errors = 0;
  item_t expq[$];
  logic [63:0] log_q[$];
  int unsigned m_exp, m_rcv, m_popped;
  logic [15:0] m_csum, m_fcnt;
  logic        m_ovf;
  int          ready_mode = 0;
  int          tcnt = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_trailer();
    logic [31:0] s;
    s = m_exp;
    expq.push_back('{{16'h5AA5, s[15:0], s[31:16], m_csum}, 1'b0});
    m_fcnt++;
  endtask

  // Acceptance rule: within the expected count and with room in the buffer.
  task automatic feed(logic [63:0] w);
    if (m_rcv < m_exp && (m_rcv - m_popped) < DEPTH) begin
      expq.push_back('{w, 1'b1});
      m_csum ^= w[63:48] ^ w[47:32] ^ w[31:16] ^ w[15:0];
      m_rcv++;
      if (m_rcv == m_exp) push_trailer();
    end else m_ovf = 1'b1;
  endtask

  task automatic start_frame(logic [15:0] np, logic [15:0] nb, logic [15:0] pc,
                             bit with_w, logic [63:0] w);
    frame_start_i = 1'b1; n_points_i = np; n_bins_i = nb; pulse_count_i = pc;
    valid_i = with_w; data_i = w;
    m_exp = 32'(np) * 32'(nb); m_rcv = 0; m_popped = 0; m_csum = '0;
    expq.push_back('{{16'hA55A, m_fcnt, nb, pc}, 1'b0});
    if (m_exp == 0) push_trailer();
    if (with_w) feed(w);
    tick();
    frame_start_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic send(int n, logic [63:0] base, bit rnd);
    for (int i = 0; i < n; i++) begin
      data_i  = rnd ? {$urandom, $urandom} : base + 64'(i);
      valid_i = 1'b1;
      feed(data_i);
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    while ((expq.size() != 0 || busy_o) && k < 300) begin tick(); k++; end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL %s_timeout: queue %0d busy %b, required empty/idle", name, expq.size(), busy_o);
    end
    chk({name, "_fcnt"}, 64'(frame_cnt_o), 64'(m_fcnt));
    chk({name, "_ovf"}, 64'(overflow_o), 64'(m_ovf));
    chk({name, "_dv"}, 64'(data_valid_o), 64'd0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset(string name);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk({name, "_y"}, {y0, y0z, y1, y1z}, 64'd0);
    chk({name, "_dv"}, 64'(data_valid_o), 64'd0);
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_ovf"}, 64'(overflow_o), 64'd0);
    chk({name, "_fcnt"}, 64'(frame_cnt_o), 64'd0);
    expq.delete(); m_fcnt = '0; m_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Ready pattern driver: 0 = always ready, 1 = 1,0,0 repeating, 2 = stalled.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      tcnt++;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (tcnt % 3 == 0);
        default: ready_i = 1'b0;
      endcase
    end
  end

  // Compare process: every transfer against the model, and stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("stall_data", {y0, y0z, y1, y1z}, prev_data);
          chk("stall_valid", 64'(data_valid_o), 64'd1);
        end
        if (data_valid_o && ready_i) begin
          log_q.push_back({y0, y0z, y1, y1z});
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h, required no transfer", {y0, y0z, y1, y1z});
          end else begin
            item_t it;
            it = expq.pop_front();
            chk("word", {y0, y0z, y1, y1z}, it.w);
            if (it.pay) m_popped++;
          end
        end
        prev_stall = data_valid_o && !ready_i;
        prev_data  = {y0, y0z, y1, y1z};
      end
    end
  end

  initial begin
    rst_n = 1'b0; frame_start_i = 1'b0; valid_i = 1'b0; data_i = '0;
    n_points_i = '0; n_bins_i = '0; pulse_count_i = '0;
    m_fcnt = '0; m_ovf = 1'b0; m_exp = 0; m_rcv = 0; m_popped = 0; m_csum = '0;
    #2;
    chk("reset_y", {y0, y0z, y1, y1z}, 64'd0);
    chk("reset_dv", 64'(data_valid_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_ovf", 64'(overflow_o), 64'd0);
    chk("reset_fcnt", 64'(frame_cnt_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic frame, always ready.
    log_q.delete();
    start_frame(16'd4, 16'd2, 16'd100, 1'b0, 64'd0);
    chk("t1_busy", 64'(busy_o), 64'd1);
    send(8, 64'h0001_0002_0003_0004, 1'b0);
    wait_idle("t1");
    chk("t1_len", 64'(log_q.size()), 64'd10);
    chk("t1_hdr", log_q[0], 64'hA55A_0000_0002_0064);
    chk("t1_p0", log_q[1], 64'h0001_0002_0003_0004);
    chk("t1_trl", log_q[9], 64'h5AA5_0008_0000_0000);

    // Same frame with ready toggling 1,0,0.
    log_q.delete();
    ready_mode = 1;
    start_frame(16'd4, 16'd2, 16'd100, 1'b0, 64'd0);
    send(8, 64'h0001_0002_0003_0004, 1'b0);
    wait_idle("t2");
    chk("t2_len", 64'(log_q.size()), 64'd10);
    chk("t2_hdr", log_q[0], 64'hA55A_0001_0002_0064);
    chk("t2_p7", log_q[8], 64'h0001_0002_0003_000B);
    ready_mode = 0;

    // Random payload, first word in the same cycle as the start pulse.
    start_frame(16'd3, 16'd2, 16'hBEEF, 1'b1, 64'h1234_5678_9ABC_DEF0);
    send(5, 64'd0, 1'b1);
    wait_idle("t3");

    // Empty frame; a second start while busy is ignored.
    log_q.delete();
    ready_mode = 2;
    start_frame(16'd0, 16'd3, 16'd7, 1'b0, 64'd0);
    tick();
    frame_start_i = 1'b1; n_points_i = 16'd5; n_bins_i = 16'd5;
    tick();
    frame_start_i = 1'b0;
    chk("t4_busy", 64'(busy_o), 64'd1);
    ready_mode = 0;
    wait_idle("t4");
    chk("t4_len", 64'(log_q.size()), 64'd2);
    chk("t4_hdr", log_q[0], 64'hA55A_0003_0003_0007);
    chk("t4_trl", log_q[1], 64'h5AA5_0000_0000_0000);

    // Excess words beyond the expected count; overflow sticks.
    log_q.delete();
    start_frame(16'd2, 16'd2, 16'd5, 1'b0, 64'd0);
    send(6, 64'hCAFE_0000_0000_0010, 1'b0);
    wait_idle("t5");
    chk("t5_len", 64'(log_q.size()), 64'd6);
    chk("t5_ovf_lit", 64'(overflow_o), 64'd1);
    start_frame(16'd1, 16'd1, 16'd9, 1'b0, 64'd0);
    send(1, 64'h0000_0000_0000_0077, 1'b0);
    wait_idle("t5b");
    chk("t5b_ovf_lit", 64'(overflow_o), 64'd1);

    mid_reset("rst1");

    // FIFO overflow under full backpressure, then drain and stall in payload.
    log_q.delete();
    ready_mode = 2;
    start_frame(16'd4, 16'd5, 16'h0011, 1'b0, 64'd0);
    send(DEPTH + 2, 64'hF000_0000_0000_0100, 1'b0);
    chk("t6_ovf", 64'(overflow_o), 64'(m_ovf));
    chk("t6_ovf_lit", 64'(overflow_o), 64'd1);
    ready_mode = 0;
    begin
      int k = 0;
      while (expq.size() != 0 && k < 200) begin tick(); k++; end
      checks++;
      if (k >= 200) begin
        errors++;
        $display("FAIL t6_drain_timeout: %0d words pending, required 0", expq.size());
      end
    end
    repeat (3) tick();
    chk("t6_len", 64'(log_q.size()), 64'(DEPTH + 1));
    chk("t6_busy", 64'(busy_o), 64'd1);
    chk("t6_dv", 64'(data_valid_o), 64'd0);
    chk("t6_fcnt", 64'(frame_cnt_o), 64'd0);

    mid_reset("rst2");
    chk("end_queue", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
